// File: rtl/instruction_decode_pkg.sv
// Shared encodings for the decode stage: opcodes, bubble word, fetch mux selects
// and the ID/EX pipeline register layout.
package instruction_decode_pkg;

  localparam int RF_DEPTH = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  localparam logic [31:0] NOP_WORD = 32'h0000_0001;

  localparam logic [1:0] PCSEL_INC  = 2'd1;
  localparam logic [1:0] PCSEL_HOLD = 2'd2;
  localparam logic [1:0] PCSEL_BR   = 2'd3;
  localparam logic [1:0] IRSEL_NEW  = 2'd0;
  localparam logic [1:0] IRSEL_NOP  = 2'd1;
  localparam logic [1:0] IRSEL_HOLD = 2'd2;

  typedef enum logic [2:0] {
    K_BUBBLE,
    K_RTYPE,
    K_ADDI,
    K_LW,
    K_SW,
    K_BEQ,
    K_ILLEGAL
  } instr_kind_e;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [5:0]  funct;
  } idex_t;

  // The bubble word has opcode 0, so it must be recognised before R-type.
  function automatic instr_kind_e classify(input logic [31:0] ir);
    instr_kind_e kind;
    if (ir == NOP_WORD) begin
      kind = K_BUBBLE;
    end else begin
      case (ir[31:26])
        OP_RTYPE: kind = K_RTYPE;
        OP_ADDI:  kind = K_ADDI;
        OP_LW:    kind = K_LW;
        OP_SW:    kind = K_SW;
        OP_BEQ:   kind = K_BEQ;
        default:  kind = K_ILLEGAL;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/instruction_decode_regfile.sv
// 32x32 register file: two combinational read ports with write-first bypass,
// one write port, synchronous clear; r0 is hardwired to zero.
module instruction_decode_regfile
  import instruction_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);

  logic [31:0] rf_q [RF_DEPTH];

  // NOTE: clearing every entry on reset rules out a RAM macro; the array becomes
  // flops, which the architectural all-zero reset state requires anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != '0) begin
      rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : rf_q[raddr_a_i];
    end
    if (raddr_b_i != '0) begin
      rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : rf_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: register read, BEQ resolution, load-use/branch hazard stalls,
// fetch mux control, and the ID/EX pipeline register.
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir2output,
  input  logic [31:0] pc2output,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_dest,
  output logic [1:0]  selectmux0,
  output logic [1:0]  selectmux1,
  output logic        selectmux2,
  output logic [31:0] branchaddress,
  output logic        idex_valid,
  output logic        idex_regwrite,
  output logic        idex_memread,
  output logic        idex_memwrite,
  output logic        idex_alusrc,
  output logic [31:0] idex_pc,
  output logic [31:0] idex_a,
  output logic [31:0] idex_b,
  output logic [31:0] idex_imm,
  output logic [4:0]  idex_dest,
  output logic [5:0]  idex_funct,
  output logic        illegal_instr
);

  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, op_a, op_b;
  instr_kind_e kind;
  logic        rt_is_src, load_use, branch_hazard, stall, taken;
  idex_t       idex_d, idex_q;
  logic        illegal_d, illegal_q;

  assign rs       = ir2output[25:21];
  assign rt       = ir2output[20:16];
  assign rd       = ir2output[15:11];
  assign imm_sext = {{16{ir2output[15]}}, ir2output[15:0]};
  assign kind     = classify(ir2output);

  assign branchaddress = pc2output + {imm_sext[29:0], 2'b00};

  instruction_decode_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (op_a),
    .rdata_b_o (op_b)
  );

  // Hazards look at the ID/EX register (one ahead) and at MEM (two ahead).
  assign rt_is_src = (kind == K_RTYPE) || (kind == K_SW) || (kind == K_BEQ);
  assign load_use  = idex_q.valid && idex_q.memread && (idex_q.dest != '0) &&
                     ((idex_q.dest == rs) || (rt_is_src && (idex_q.dest == rt)));
  assign branch_hazard = (kind == K_BEQ) && (
      (idex_q.valid && idex_q.regwrite && (idex_q.dest != '0) &&
       ((idex_q.dest == rs) || (idex_q.dest == rt))) ||
      (mem_regwrite && (mem_dest != '0) && ((mem_dest == rs) || (mem_dest == rt))));
  assign stall = load_use || branch_hazard;
  assign taken = (kind == K_BEQ) && !stall && (op_a == op_b);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can leave one unassigned and infer a latch.
  always_comb begin
    selectmux0 = PCSEL_INC;
    selectmux1 = IRSEL_NEW;
    selectmux2 = 1'b0;
    if (!reset) begin
      if (stall) begin
        selectmux0 = PCSEL_HOLD;
        selectmux1 = IRSEL_HOLD;
        selectmux2 = 1'b1;
      end else if (taken) begin
        selectmux0 = PCSEL_BR;
        selectmux1 = IRSEL_NOP;
      end
    end
  end

  always_comb begin
    idex_d    = '0;
    illegal_d = 1'b0;
    if (!stall) begin
      if ((kind == K_RTYPE) || (kind == K_ADDI) || (kind == K_LW) || (kind == K_SW)) begin
        idex_d.valid  = 1'b1;
        idex_d.pc     = pc2output;
        idex_d.a      = op_a;
        idex_d.b      = op_b;
        idex_d.imm    = imm_sext;
        idex_d.funct  = FUNCT_ADD;
        idex_d.alusrc = 1'b1;
      end
      case (kind)
        K_RTYPE: begin
          idex_d.alusrc   = 1'b0;
          idex_d.regwrite = 1'b1;
          idex_d.dest     = rd;
          idex_d.funct    = ir2output[5:0];
        end
        K_ADDI: begin
          idex_d.regwrite = 1'b1;
          idex_d.dest     = rt;
        end
        K_LW: begin
          idex_d.regwrite = 1'b1;
          idex_d.memread  = 1'b1;
          idex_d.dest     = rt;
        end
        K_SW:      idex_d.memwrite = 1'b1;
        K_ILLEGAL: illegal_d = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      illegal_q <= illegal_d;
    end
  end

  assign idex_valid    = idex_q.valid;
  assign idex_regwrite = idex_q.regwrite;
  assign idex_memread  = idex_q.memread;
  assign idex_memwrite = idex_q.memwrite;
  assign idex_alusrc   = idex_q.alusrc;
  assign idex_pc       = idex_q.pc;
  assign idex_a        = idex_q.a;
  assign idex_b        = idex_q.b;
  assign idex_imm      = idex_q.imm;
  assign idex_dest     = idex_q.dest;
  assign idex_funct    = idex_q.funct;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a rule-level model.
module tb_instruction_decode;
  import instruction_decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir2output, pc2output, wb_data;
  logic        wb_we, mem_regwrite;
  logic [4:0]  wb_addr, mem_dest;
  logic [1:0]  selectmux0, selectmux1;
  logic        selectmux2;
  logic [31:0] branchaddress;
  logic        idex_valid, idex_regwrite, idex_memread, idex_memwrite, idex_alusrc;
  logic [31:0] idex_pc, idex_a, idex_b, idex_imm;
  logic [4:0]  idex_dest;
  logic [5:0]  idex_funct;
  logic        illegal_instr;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk           (clk),
    .reset         (reset),
    .ir2output     (ir2output),
    .pc2output     (pc2output),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .mem_regwrite  (mem_regwrite),
    .mem_dest      (mem_dest),
    .selectmux0    (selectmux0),
    .selectmux1    (selectmux1),
    .selectmux2    (selectmux2),
    .branchaddress (branchaddress),
    .idex_valid    (idex_valid),
    .idex_regwrite (idex_regwrite),
    .idex_memread  (idex_memread),
    .idex_memwrite (idex_memwrite),
    .idex_alusrc   (idex_alusrc),
    .idex_pc       (idex_pc),
    .idex_a        (idex_a),
    .idex_b        (idex_b),
    .idex_imm      (idex_imm),
    .idex_dest     (idex_dest),
    .idex_funct    (idex_funct),
    .illegal_instr (illegal_instr)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: architectural registers and what ID/EX should hold.
  logic [31:0] m_rf [32];
  idex_t       m_q;
  logic        m_ill;
  logic        m_stall;

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic idex_t model_next();
    idex_t       r;
    logic [5:0]  op;
    logic [31:0] sx;
    r  = '0;
    op = ir2output[31:26];
    sx = int'($signed(ir2output[15:0]));
    if (ir2output == 32'h1) return r;
    if (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
      r.valid  = 1'b1;
      r.pc     = pc2output;
      r.a      = m_read(ir2output[25:21]);
      r.b      = m_read(ir2output[20:16]);
      r.imm    = sx;
      r.alusrc = 1'b1;
      r.funct  = 6'h20;
    end
    case (op)
      6'h00: begin r.alusrc = 1'b0; r.regwrite = 1'b1; r.dest = ir2output[15:11]; r.funct = ir2output[5:0]; end
      6'h08: begin r.regwrite = 1'b1; r.dest = ir2output[20:16]; end
      6'h23: begin r.regwrite = 1'b1; r.memread = 1'b1; r.dest = ir2output[20:16]; end
      6'h2B: r.memwrite = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic is_unknown_op(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    if (ir == 32'h1) return 1'b0;
    return !(op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04);
  endfunction

  task automatic model_comb(output logic [1:0] s0, output logic [1:0] s1, output logic s2,
                            output logic [31:0] ba, output logic stall);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       is_beq, rt_src, lu, bh;
    op     = ir2output[31:26];
    rs     = ir2output[25:21];
    rt     = ir2output[20:16];
    is_beq = (op == 6'h04);
    rt_src = (op == 6'h00 && ir2output != 32'h1) || op == 6'h2B || is_beq;
    lu = m_q.valid && m_q.memread && m_q.dest != 0 &&
         (m_q.dest == rs || (rt_src && m_q.dest == rt));
    bh = is_beq && ((m_q.valid && m_q.regwrite && m_q.dest != 0 && (m_q.dest == rs || m_q.dest == rt)) ||
                    (mem_regwrite && mem_dest != 0 && (mem_dest == rs || mem_dest == rt)));
    stall = lu || bh;
    ba = pc2output + 32'(int'($signed(ir2output[15:0])) * 4);
    s0 = 2'd1; s1 = 2'd0; s2 = 1'b0;
    if (!reset) begin
      if (stall) begin
        s0 = 2'd2; s1 = 2'd2; s2 = 1'b1;
      end else if (is_beq && m_read(rs) == m_read(rt)) begin
        s0 = 2'd3; s1 = 2'd1;
      end
    end
  endtask

  // One clock: check combinational selects before the edge, advance the model
  // at the edge, check the ID/EX register on the following falling edge.
  task automatic tick();
    logic [1:0]  e0, e1;
    logic        e2;
    logic [31:0] eba;
    idex_t       nq;
    #1;
    model_comb(e0, e1, e2, eba, m_stall);
    check("selectmux0", 32'(selectmux0), 32'(e0));
    check("selectmux1", 32'(selectmux1), 32'(e1));
    check("selectmux2", 32'(selectmux2), 32'(e2));
    check("branchaddress", branchaddress, eba);
    nq = model_next();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_q   = '0;
      m_ill = 1'b0;
    end else begin
      m_ill = !m_stall && is_unknown_op(ir2output);
      m_q   = m_stall ? '0 : nq;
      if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
    @(negedge clk);
    check("idex_ctrl", {27'd0, idex_valid, idex_regwrite, idex_memread, idex_memwrite, idex_alusrc},
          {27'd0, m_q.valid, m_q.regwrite, m_q.memread, m_q.memwrite, m_q.alusrc});
    check("idex_pc", idex_pc, m_q.pc);
    check("idex_a", idex_a, m_q.a);
    check("idex_b", idex_b, m_q.b);
    check("idex_imm", idex_imm, m_q.imm);
    check("idex_dest", 32'(idex_dest), 32'(m_q.dest));
    check("idex_funct", 32'(idex_funct), 32'(m_q.funct));
    check("illegal_instr", 32'(illegal_instr), 32'(m_ill));
  endtask

  function automatic logic [31:0] rtype(input int s, input int t, input int d);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [31:0] w;
    int          k;
    k = $urandom_range(0, 9);
    w = $urandom;
    case (k)
      0, 1: w = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), w[10:0]};
      2:    w = itype(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), w[15:0]);
      3:    w = itype(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), w[15:0]);
      4:    w = itype(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), w[15:0]);
      5, 6: w = itype(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), w[15:0]);
      7:    w = 32'h1;
      8: begin
        op = 6'($urandom_range(0, 63));
        if (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04) op = 6'h3F;
        w = {op, 5'($urandom_range(0, 7)), w[20:0]};
      end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    m_q          = '0;
    m_ill        = 1'b0;
    reset        = 1'b1;
    ir2output    = 32'h1;
    pc2output    = 32'h0;
    wb_we        = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
    mem_regwrite = 1'b0;
    mem_dest     = '0;
    @(negedge clk);

    tick(); tick();
    check("reset_valid", 32'(idex_valid), 32'd0);
    check("reset_illegal", 32'(illegal_instr), 32'd0);
    reset = 1'b0;

    ir2output = itype(6'h08, 0, 1, 16'd5);
    pc2output = 32'h40;
    #1;
    check("addi_sel0", 32'(selectmux0), 32'd1);
    check("addi_sel1", 32'(selectmux1), 32'd0);
    check("addi_sel2", 32'(selectmux2), 32'd0);
    tick();
    check("addi_dest", 32'(idex_dest), 32'd1);
    check("addi_imm", idex_imm, 32'd5);
    check("addi_alusrc", 32'(idex_alusrc), 32'd1);
    check("addi_valid", 32'(idex_valid), 32'd1);

    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    ir2output = rtype(3, 3, 4);
    tick();
    check("bypass_a", idex_a, 32'hDEAD_BEEF);
    check("bypass_b", idex_b, 32'hDEAD_BEEF);

    wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    ir2output = rtype(0, 0, 5);
    tick();
    check("r0_bypass", idex_a, 32'd0);
    wb_we = 1'b0;
    tick();
    check("r0_after_write", idex_b, 32'd0);

    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    ir2output = 32'h1;
    tick();
    wb_we = 1'b0;

    ir2output = itype(6'h23, 1, 2, 16'd0);
    tick();
    check("lw_memread", 32'(idex_memread), 32'd1);
    check("lw_a", idex_a, 32'd7);
    ir2output = rtype(2, 2, 5);
    #1;
    check("lu_sel0", 32'(selectmux0), 32'd2);
    check("lu_sel1", 32'(selectmux1), 32'd2);
    check("lu_sel2", 32'(selectmux2), 32'd1);
    tick();
    check("lu_bubble", 32'(idex_valid), 32'd0);
    #1;
    check("lu_release", 32'(selectmux0), 32'd1);
    tick();
    check("lu_add_valid", 32'(idex_valid), 32'd1);
    check("lu_add_dest", 32'(idex_dest), 32'd5);

    ir2output = itype(6'h04, 0, 0, 16'd3);
    pc2output = 32'h100;
    #1;
    check("beq_taken_sel0", 32'(selectmux0), 32'd3);
    check("beq_taken_addr", branchaddress, 32'h10C);
    check("beq_taken_sel1", 32'(selectmux1), 32'd1);
    check("beq_taken_sel2", 32'(selectmux2), 32'd0);
    tick();
    check("beq_no_idex", 32'(idex_valid), 32'd0);

    ir2output = itype(6'h04, 1, 0, 16'hFFFF);
    #1;
    check("beq_nt_sel0", 32'(selectmux0), 32'd1);
    check("beq_nt_sel1", 32'(selectmux1), 32'd0);
    check("beq_back_addr", branchaddress, 32'h100 - 32'd4);
    tick();

    ir2output = itype(6'h04, 6, 0, 16'd2);
    mem_regwrite = 1'b1; mem_dest = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("beq_mem_stall0", 32'(selectmux0), 32'd2);
      check("beq_mem_stall2", 32'(selectmux2), 32'd1);
      tick();
    end
    mem_regwrite = 1'b0;
    #1;
    check("beq_mem_release", 32'(selectmux0), 32'd3);
    tick();

    ir2output = 32'hFC00_0000;
    tick();
    check("illegal_pulse", 32'(illegal_instr), 32'd1);
    check("illegal_valid", 32'(idex_valid), 32'd0);
    ir2output = 32'h1;
    tick();
    check("illegal_drop", 32'(illegal_instr), 32'd0);

    ir2output = itype(6'h23, 1, 2, 16'd8);
    tick();
    ir2output = rtype(2, 2, 5);
    #1;
    check("rst_pre_stall", 32'(selectmux0), 32'd2);
    reset = 1'b1;
    #1;
    check("rst_sel0", 32'(selectmux0), 32'd1);
    check("rst_sel1", 32'(selectmux1), 32'd0);
    check("rst_sel2", 32'(selectmux2), 32'd0);
    tick();
    check("rst_valid", 32'(idex_valid), 32'd0);
    check("rst_memread", 32'(idex_memread), 32'd0);
    check("rst_dest", 32'(idex_dest), 32'd0);
    check("rst_pc", idex_pc, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_after_sel0", 32'(selectmux0), 32'd1);
    tick();
    check("rst_add_issue", 32'(idex_valid), 32'd1);

    for (int n = 0; n < 1500; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      ir2output    = rand_instr();
      pc2output    = $urandom;
      wb_we        = $urandom_range(0, 1) == 1;
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      mem_regwrite = $urandom_range(0, 3) == 0;
      mem_dest     = 5'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
